// File: rtl/mux_share_arbiter.sv
// Four-way round-robin arbiter that drives a shared N-bit bus from the granted requester.
// A grant covers one burst; it ends on an accepted last word, a dropped request, or a stall timeout.
module mux_share_arbiter #(
    parameter int N       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req,
    input  logic [3:0][N-1:0]   J,
    input  logic [3:0]          last,
    input  logic                ready,
    output logic [3:0]          gnt,
    output logic [1:0]          s,
    output logic [N-1:0]        w,
    output logic                valid,
    output logic [3:0]          ack
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      s_q, s_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      pick_s;
    logic            found_s;

    // Round-robin search starting one past the last-granted index.
    always_comb begin
        pick_s  = 2'd0;
        found_s = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!found_s && req[ptr_q + 2'(i)]) begin
                pick_s  = ptr_q + 2'(i);
                found_s = 1'b1;
            end else begin
                pick_s  = pick_s;
                found_s = found_s;
            end
        end
    end

    // Next-state logic; abort has priority over accept, and accept resets the stall counter.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = {CW{1'b0}};
                if (found_s) begin
                    state_d = BUSY;
                    s_d     = pick_s;
                    ptr_d   = pick_s;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (!req[s_q]) begin
                    state_d = IDLE;
                    cnt_d   = {CW{1'b0}};
                end else if (ready) begin
                    cnt_d   = {CW{1'b0}};
                    if (last[s_q]) begin
                        state_d = IDLE;
                    end else begin
                        state_d = BUSY;
                    end
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State register with synchronous active-low reset; ptr resets to 3 so requester 0 leads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            s_q     <= 2'd0;
            ptr_q   <= 2'd3;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus outputs decode from the registered select so the mux has no arbitration path.
    always_comb begin
        gnt   = 4'b0000;
        w     = {N{1'b0}};
        valid = 1'b0;
        ack   = 4'b0000;
        s     = s_q;
        case (state_q)
            BUSY: begin
                gnt   = 4'b0001 << s_q;
                w     = J[s_q];
                valid = req[s_q];
                if (req[s_q] && ready) begin
                    ack = 4'b0001 << s_q;
                end else begin
                    ack = 4'b0000;
                end
            end
            IDLE: begin
                gnt   = 4'b0000;
                valid = 1'b0;
            end
            default: begin
                gnt   = 4'b0000;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mux_share_arbiter.md
MUX_SHARE_ARBITER -- requirements
Module: mux_share_arbiter

Interface
REQ-001 Parameter: N, default 8, width of each requester's data word and of the shared output bus.
REQ-002 Parameter: TIMEOUT, default 15, maximum number of cycles a grant is held without a completed transfer.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-low (rst=0 sampled at a rising edge resets the block).
REQ-005 Port: req  input  4  per-requester request, one bit per requester 0..3.
REQ-006 Port: J  input  4xN  packed per-requester data, J[k] belonging to requester k.
REQ-007 Port: last  input  4  per-requester end-of-burst flag, qualifying the current word.
REQ-008 Port: ready  input  1  downstream accepts the word on w this cycle.
REQ-009 Port: gnt  output  4  one-hot grant; all zero when idle.
REQ-010 Port: s  output  2  mux select, equal to the index of the granted requester.
REQ-011 Port: w  output  N  shared bus, equal to J[s] while a grant is held, else 0.
REQ-012 Port: valid  output  1  w carries a word from the granted requester.
REQ-013 Port: ack  output  4  one-hot, pulsed for the granted requester on each accepted word.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-015 IDLE: gnt=0, valid=0, w=0; if any req bit is 1, the FSM SHALL register a grant and enter BUSY on the next edge.
REQ-016 Arbitration SHALL be round-robin: search starts at index (ptr+1) mod 4, where ptr is the last-granted index, and the first set req bit wins.
REQ-017 On a grant, ptr SHALL update to the granted index; ptr SHALL not change otherwise.
REQ-018 Latency: from req rising in IDLE to gnt/valid asserted SHALL be exactly 1 cycle.
REQ-019 BUSY: gnt=onehot(s), valid=req[s], w=J[s] combinationally from registered s.
REQ-020 A word SHALL be accepted in a cycle with valid=1 and ready=1; ack[s] SHALL be 1 in that same cycle only.
REQ-021 If an accepted word has last[s]=1, the FSM SHALL release the grant and return to IDLE next cycle.
REQ-022 There SHALL be no back-to-back grants: at least one IDLE cycle separates bursts.
REQ-023 If req[s] drops while in BUSY, the FSM SHALL return to IDLE next cycle (burst abort), with no ack issued.
REQ-024 A cycle counter SHALL be cleared on grant and on each accepted word, and incremented otherwise in BUSY.
REQ-025 When the counter reaches TIMEOUT, the grant SHALL be released and the FSM SHALL enter IDLE next cycle.
REQ-026 Changes to req of non-granted requesters during BUSY SHALL have no effect on s, gnt, or w.
REQ-027 When only one requester is active, it SHALL be re-granted after each IDLE gap (no starvation of the sole requester).

Reset
REQ-028 With rst=0, the block SHALL enter IDLE with gnt=0, s=0, valid=0, w=0, ack=0, counter=0, and ptr=3 (so requester 0 has first priority).
REQ-029 Reset asserted mid-burst SHALL abort the burst at that edge, with no ack in the following cycle.

Verification
REQ-030 Bench: after reset, req=4'b1111 with last=1 on all and ready=1 -> grants in order 0,1,2,3,0, each 1 cycle BUSY followed by 1 cycle IDLE.
REQ-031 Bench: N=8, req[2]=1, J[2]=8'hA5, ready=0 for 3 cycles, then ready=1 with last[2]=1 -> s=2, w=8'hA5 and valid=1 throughout, ack=4'b0100 only on the ready cycle, then IDLE.
REQ-032 Bench: 3-word burst from requester 1 (last on word 3) while req[0] is held -> ack[1] pulses 3 times, then IDLE, then gnt=4'b0001.
REQ-033 Bench: grant to requester 3 with ready held 0 -> release after TIMEOUT (15) cycles with no ack, then IDLE.
REQ-034 Bench: rst=0 asserted during BUSY -> next cycle gnt=0, w=0, s=0, and the next grant goes to the lowest active index.
REQ-035 Bench: req[s] dropped mid-burst -> IDLE next cycle, no ack, and ptr retains the aborted index.
